euler_step_accumulator: RTL and testbench

Downstream integration stage for the fixed-point arithmetic core. It consumes the core's signed 9-bit result as a derivative sample and advances a 9-bit signed state by one explicit Euler step per accepted sample: x ← sat(x + (dx >>> SHIFT)). It runs a fixed number of steps per start command and then signals completion. Together with the arithmetic core it forms the basic ODE-integration loop.

---
 rtl/euler_step_accumulator.sv | 75 +++++++
 tb/tb_euler_step_accumulator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/euler_step_accumulator.sv
// euler_step_accumulator: fixed-length explicit Euler integrator with saturating 9-bit state
module euler_step_accumulator #(
  parameter int unsigned       STEPS = 64,
  parameter int unsigned       SHIFT = 3,
  parameter logic signed [8:0] INIT  = 9'sd0
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              start,
  input  logic signed [8:0] deriv_i,
  input  logic              deriv_valid,
  output logic              deriv_ready,
  output logic signed [8:0] state_o,
  output logic              state_valid,
  output logic [15:0]       step_o,
  output logic              sat_o,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
  localparam logic [15:0] LAST = 16'(STEPS - 1);
  fsm_t              fsm_q, fsm_d;
  logic signed [8:0] state_q, state_d, inc;
  logic signed [9:0] sum;
  logic [15:0]       step_q, step_d;
  logic              sat_q, sat_d, valid_q, valid_d, accept, ovf;
  // candidate Euler update; sum bits 9:8 disagreeing means it left the 9-bit range
  always_comb begin
    inc    = deriv_i >>> SHIFT;
    sum    = {state_q[8], state_q} + {inc[8], inc};
    ovf    = sum[9] ^ sum[8];
    accept = (fsm_q == RUN) && deriv_valid;
  end
  // next state: (re)load on start outside RUN, one saturating step per accept
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    step_d  = step_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    if ((fsm_q != RUN) && start) begin
      fsm_d   = RUN;
      state_d = INIT;
      step_d  = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      state_d = !ovf ? sum[8:0] : sum[9] ? 9'h100 : 9'h0ff;
      sat_d   = sat_q | ovf;
      step_d  = step_q + 16'd1;
      valid_d = 1'b1;
      fsm_d   = (step_q == LAST) ? DONE : RUN;
    end
  end
  // state registers; reset clears the run and discards any in-flight sample
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      step_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      step_q  <= step_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end
  assign deriv_ready = fsm_q == RUN;
  assign done        = fsm_q == DONE;
  assign state_o     = state_q;
  assign state_valid = valid_q;
  assign step_o      = step_q;
  assign sat_o       = sat_q;
endmodule

// File: tb/tb_euler_step_accumulator.sv
// tb_euler_step_accumulator: randomized and directed checks of three differently parameterised integrators
module tb_euler_step_accumulator;
  logic       clk, rst, start, deriv_valid;
  logic [8:0] deriv_i;
  logic [8:0] so[3];
  logic [15:0] sn[3];
  logic       sv[3], ss[3], sd[3], sr[3];
  int tests = 0, fails = 0;
  int p_steps[3] = '{64, 4, 4};
  int p_init[3]  = '{0, 250, -250};
  int p_shift = 3;
  int mx[3], mn[3];
  bit msat[3], mrun[3], mfin[3], mvld[3];

  euler_step_accumulator #(.STEPS(64), .SHIFT(3), .INIT(9'sd0)) u0 (
    .system1000(clk), .system1000_rst(rst), .start(start), .deriv_i(deriv_i), .deriv_valid(deriv_valid),
    .deriv_ready(sr[0]), .state_o(so[0]), .state_valid(sv[0]), .step_o(sn[0]), .sat_o(ss[0]), .done(sd[0]));
  euler_step_accumulator #(.STEPS(4), .SHIFT(3), .INIT(9'sd250)) u1 (
    .system1000(clk), .system1000_rst(rst), .start(start), .deriv_i(deriv_i), .deriv_valid(deriv_valid),
    .deriv_ready(sr[1]), .state_o(so[1]), .state_valid(sv[1]), .step_o(sn[1]), .sat_o(ss[1]), .done(sd[1]));
  euler_step_accumulator #(.STEPS(4), .SHIFT(3), .INIT(-9'sd250)) u2 (
    .system1000(clk), .system1000_rst(rst), .start(start), .deriv_i(deriv_i), .deriv_valid(deriv_valid),
    .deriv_ready(sr[2]), .state_o(so[2]), .state_valid(sv[2]), .step_o(sn[2]), .sat_o(ss[2]), .done(sd[2]));

  always #5 clk = ~clk;

  function automatic int floor_div(int d, int s);
    int p = 1 << s;
    return (d >= 0) ? d / p : -((-d + p - 1) / p);
  endfunction

  function automatic logic [28:0] got(int i);
    return {so[i], sv[i], sn[i], ss[i], sd[i], sr[i]};
  endfunction

  function automatic logic [28:0] exp_v(int i);
    int x = mx[i];
    int n = mn[i];
    return {x[8:0], mvld[i], n[15:0], msat[i], mfin[i], mrun[i]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 0; mn[i] = 0; msat[i] = 0; mrun[i] = 0; mfin[i] = 0; mvld[i] = 0;
    end
  endtask

  task automatic model_step(bit st, bit dv, int d);
    for (int i = 0; i < 3; i++) begin
      int y;
      mvld[i] = 0;
      if (!mrun[i]) begin
        if (st) begin
          mx[i] = p_init[i]; mn[i] = 0; msat[i] = 0; mrun[i] = 1; mfin[i] = 0;
        end
      end else if (dv) begin
        y = mx[i] + floor_div(d, p_shift);
        if (y > 255 || y < -256) msat[i] = 1;
        mx[i] = (y > 255) ? 255 : (y < -256) ? -256 : y;
        mn[i]++;
        mvld[i] = 1;
        if (mn[i] == p_steps[i]) begin
          mrun[i] = 0; mfin[i] = 1;
        end
      end
    end
  endtask

  task automatic drive(bit st, bit dv, int d);
    @(negedge clk);
    start = st; deriv_valid = dv; deriv_i = 9'(d);
    @(posedge clk);
    if (rst) model_clear(); else model_step(st, dv, d);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 0; start = 0; deriv_valid = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (got(0) !== 29'd0) begin fails++; $display("FAIL reset_async u0 got %h want 0", got(0)); end
    for (int k = 0; k < 3; k++) begin
      drive(1'($urandom_range(0, 1)), 1, $urandom_range(0, 511) - 256);
      for (int i = 0; i < 3; i++) begin
        tests++; if (got(i) !== exp_v(i)) begin fails++; $display("FAIL reset_hold u%0d got %h want %h", i, got(i), exp_v(i)); end
      end
    end
    release_reset();
  endtask

  task automatic test_ramp();
    drive(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 8);
      tests++; if (so[0] !== 9'(k) || sv[0] !== 1'b1) begin fails++; $display("FAIL ramp_state got %0d/%b want %0d/1", so[0], sv[0], k); end
      for (int i = 0; i < 3; i++) begin
        tests++; if (got(i) !== exp_v(i)) begin fails++; $display("FAIL ramp u%0d got %h want %h", i, got(i), exp_v(i)); end
      end
    end
    tests++; if (sn[0] !== 16'd4 || ss[0] !== 1'b0) begin fails++; $display("FAIL ramp_step got %0d/%b want 4/0", sn[0], ss[0]); end
    drive(0, 0, 0);
    tests++; if (sv[0] !== 1'b0) begin fails++; $display("FAIL ramp_pulse got %b want 0", sv[0]); end
  endtask

  task automatic test_neg_gaps();
    apply_reset(); release_reset();
    drive(1, 0, 0);
    drive(0, 1, -1);
    tests++; if (so[0] !== 9'h1ff) begin fails++; $display("FAIL neg_round got %h want 1ff", so[0]); end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, $urandom_range(0, 511) - 256);
      tests++; if (sv[0] !== 1'b0 || got(0) !== exp_v(0)) begin fails++; $display("FAIL gap got %h want %h", got(0), exp_v(0)); end
    end
    drive(0, 1, -9);
    tests++; if (so[0] !== 9'h1fd || sv[0] !== 1'b1) begin fails++; $display("FAIL neg_step got %h want 1fd", so[0]); end
  endtask

  task automatic test_saturation();
    apply_reset(); release_reset();
    drive(1, 0, 0);
    drive(0, 1, 255);
    tests++; if (so[1] !== 9'd255 || ss[1] !== 1'b1) begin fails++; $display("FAIL sat_hi got %0d/%b want 255/1", so[1], ss[1]); end
    drive(0, 1, -256);
    drive(0, 1, -256);
    tests++; if (so[2] !== 9'h100 || ss[2] !== 1'b1) begin fails++; $display("FAIL sat_lo got %h/%b want 100/1", so[2], ss[2]); end
    tests++; if (ss[1] !== 1'b1) begin fails++; $display("FAIL sat_sticky got %b want 1", ss[1]); end
    drive(0, 1, -256);
    drive(0, 1, 100);
    for (int i = 0; i < 3; i++) begin
      tests++; if (got(i) !== exp_v(i)) begin fails++; $display("FAIL sat_done u%0d got %h want %h", i, got(i), exp_v(i)); end
    end
    drive(1, 0, 0);
    tests++; if (ss[1] !== 1'b0 || so[1] !== 9'd250 || sd[1] !== 1'b0) begin fails++; $display("FAIL sat_restart got %b/%0d/%b want 0/250/0", ss[1], so[1], sd[1]); end
  endtask

  task automatic test_run_length();
    apply_reset(); release_reset();
    drive(1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, 8);
      if (k == 4) begin
        tests++; if (sd[1] !== 1'b1 || sr[1] !== 1'b0 || sv[1] !== 1'b1) begin fails++; $display("FAIL last_step got done=%b rdy=%b vld=%b want 1 0 1", sd[1], sr[1], sv[1]); end
      end
    end
    tests++; if (sn[1] !== 16'd4 || sv[1] !== 1'b0 || so[1] !== 9'd254) begin fails++; $display("FAIL extra_sample got %0d/%b/%0d want 4/0/254", sn[1], sv[1], so[1]); end
    drive(1, 0, 0);
    tests++; if (sd[1] !== 1'b0 || so[1] !== 9'd250 || sn[1] !== 16'd0) begin fails++; $display("FAIL rerun got %b/%0d/%0d want 0/250/0", sd[1], so[1], sn[1]); end
  endtask

  task automatic test_mid_run_reset();
    apply_reset(); release_reset();
    drive(1, 0, 0);
    drive(0, 1, 40);
    drive(0, 1, 40);
    apply_reset();
    tests++; if (so[0] !== 9'd0 || sn[0] !== 16'd0 || sr[0] !== 1'b0) begin fails++; $display("FAIL midrst got %h want 0", got(0)); end
    release_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, $urandom_range(0, 511) - 256);
      tests++; if (sv[0] !== 1'b0 || sn[0] !== 16'd0 || got(0) !== exp_v(0)) begin fails++; $display("FAIL midrst_idle got %h want %h", got(0), exp_v(0)); end
    end
    drive(1, 0, 0);
    tests++; if (sr[0] !== 1'b1) begin fails++; $display("FAIL midrst_start got %b want 1", sr[0]); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); release_reset();
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 511) - 256);
      for (int i = 0; i < 3; i++) begin
        tests++; if (got(i) !== exp_v(i)) begin fails++; $display("FAIL random c%0d u%0d got %h want %h", k, i, got(i), exp_v(i)); end
      end
    end
  endtask

  initial begin
    clk = 0; rst = 0; start = 0; deriv_valid = 0; deriv_i = '0;
    model_clear();
    test_reset();
    test_ramp();
    test_neg_gaps();
    test_saturation();
    test_run_length();
    test_mid_run_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
